// File: rtl/keypad_encoder.sv
// rtl/keypad_encoder.sv - 4x4 matrix keypad scanner with debounce, ghost rejection and ack handshake
// Emits the 4*row+col code of each debounced press exactly once to the hex display path.
module keypad_encoder #(
    parameter int SCAN_DIV       = 4,
    parameter int DEBOUNCE_SCANS = 3
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] row_sense,
    input  logic       key_ack,
    output logic [3:0] col_drive,
    output logic [3:0] key_code,
    output logic       key_ready,
    output logic       key_held,
    output logic       overrun
);
    localparam int DW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int CW = $clog2(DEBOUNCE_SCANS + 1);

    typedef enum logic [1:0] {
        IDLE,
        PRESS_WAIT,
        HELD,
        RELEASE_WAIT
    } state_t;

    state_t        state, state_n;
    logic [DW-1:0] div_cnt;
    logic [1:0]    col;
    logic [15:0]   samples;
    logic [15:0]   scan_keys;
    logic [3:0]    cand, cand_n;
    logic [CW-1:0] cnt, cnt_n, cnt_inc;
    logic [3:0]    key_idx;
    logic          sample_now, scan_end, single, accept;

    assign sample_now = (div_cnt == DW'(SCAN_DIV - 1));
    assign scan_end   = sample_now && (col == 2'd3);
    assign col_drive  = ~(4'b0001 << col);
    assign key_held   = (state == HELD) || (state == RELEASE_WAIT);

    always_ff @(posedge clk) begin
        if (reset) begin
            div_cnt <= '0;
            col     <= '0;
            samples <= '0;
        end else if (sample_now) begin
            div_cnt <= '0;
            col     <= col + 2'd1;
            for (int r = 0; r < 4; r++) begin
                samples[4*r + int'(col)] <= ~row_sense[r];
            end
        end else begin
            div_cnt <= div_cnt + DW'(1);
        end
    end

    // Column 3 is still being driven at scan end, so its rows are taken live.
    always_comb begin
        scan_keys = samples;
        for (int r = 0; r < 4; r++) begin
            scan_keys[4*r + 3] = ~row_sense[r];
        end
    end

    always_comb begin
        key_idx = '0;
        for (int i = 0; i < 16; i++) begin
            if (scan_keys[i]) key_idx = 4'(i);
        end
    end

    // Multiple keys down can create phantom contacts, so they read as no key.
    assign single = (scan_keys != '0) && ((scan_keys & (scan_keys - 16'd1)) == '0);

    always_comb begin
        state_n = state;
        cand_n  = cand;
        cnt_n   = cnt;
        accept  = 1'b0;
        cnt_inc = cnt + CW'(1);
        if (scan_end) begin
            case (state)
                IDLE: begin
                    if (single) begin
                        state_n = PRESS_WAIT;
                        cand_n  = key_idx;
                        cnt_n   = CW'(1);
                    end
                end
                PRESS_WAIT: begin
                    if (!single) begin
                        state_n = IDLE;
                        cnt_n   = '0;
                    end else if (key_idx != cand) begin
                        cand_n = key_idx;
                        cnt_n  = CW'(1);
                    end else begin
                        cnt_n = cnt_inc;
                        if (cnt_inc == CW'(DEBOUNCE_SCANS)) begin
                            state_n = HELD;
                            accept  = 1'b1;
                        end
                    end
                end
                HELD: begin
                    if (!single) begin
                        state_n = RELEASE_WAIT;
                        cnt_n   = CW'(1);
                    end
                end
                RELEASE_WAIT: begin
                    if (single) begin
                        state_n = HELD;
                    end else if (cnt_inc == CW'(DEBOUNCE_SCANS)) begin
                        state_n = IDLE;
                        cnt_n   = '0;
                    end else begin
                        cnt_n = cnt_inc;
                    end
                end
                default: state_n = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            cand      <= '0;
            cnt       <= '0;
            key_code  <= '0;
            key_ready <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            state <= state_n;
            cand  <= cand_n;
            cnt   <= cnt_n;
            // An accept beats a same-edge ack; the ack then only clears overrun.
            if (accept) begin
                key_code  <= cand;
                key_ready <= 1'b1;
                if (key_ready) overrun <= ~key_ack;
            end else if (key_ready && key_ack) begin
                key_ready <= 1'b0;
                overrun   <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_keypad_encoder.sv
// tb/tb_keypad_encoder.sv - scoreboard bench for keypad_encoder with a scan-level reference model
module tb_keypad_encoder;
    localparam int SCAN_DIV = 4;
    localparam int DEB      = 3;
    localparam int SCAN_CYC = 4 * SCAN_DIV;
    localparam int NONE     = -1;

    typedef struct packed {
        logic [3:0] code;
        logic       ov;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  row_sense;
    logic        key_ack;
    logic [3:0]  col_drive;
    logic [3:0]  key_code;
    logic        key_ready;
    logic        key_held;
    logic        overrun;

    logic [15:0] pressed;
    logic        ack_auto;
    logic        ack_man;
    logic        auto_en;

    int tests = 0;
    int fails = 0;
    int ecnt;

    int last_res;
    int run;
    bit m_held;
    bit m_ready;
    bit m_ov;
    exp_t exp_q[$];

    keypad_encoder #(.SCAN_DIV(SCAN_DIV), .DEBOUNCE_SCANS(DEB)) dut (
        .clk       (clk),
        .reset     (reset),
        .row_sense (row_sense),
        .key_ack   (key_ack),
        .col_drive (col_drive),
        .key_code  (key_code),
        .key_ready (key_ready),
        .key_held  (key_held),
        .overrun   (overrun)
    );

    always #5 clk = ~clk;

    assign key_ack = ack_auto | ack_man;

    // Physical keypad: a pressed key pulls its row low while its column is driven low.
    always_comb begin
        row_sense = 4'hF;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                if (pressed[4*r + c] && !col_drive[c]) row_sense[r] = 1'b0;
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
        end
    endtask

    function automatic int scan_result(input logic [15:0] k);
        if ($countones(k) != 1) return NONE;
        for (int i = 0; i < 16; i++) begin
            if (k[i]) return i;
        end
        return NONE;
    endfunction

    function automatic void model_reset();
        last_res = NONE;
        run      = 0;
        m_held   = 0;
        m_ready  = 0;
        m_ov     = 0;
    endfunction

    task automatic do_reset();
        reset = 1'b1;
        @(posedge clk);
        #1;
        check("reset_col_drive", col_drive, 4'b1110);
        check("reset_key_code", key_code, 4'd0);
        check("reset_key_ready", key_ready, 1'b0);
        check("reset_key_held", key_held, 1'b0);
        check("reset_overrun", overrun, 1'b0);
        model_reset();
        @(negedge clk);
        reset = 1'b0;
        ecnt  = 0;
    endtask

    // One full scan with a fixed key set. ack_mode: 0 none, 1 mid-scan pulse, 2 on the scan-end edge.
    task automatic scan(input logic [15:0] keys, input int ack_mode);
        int         res;
        bit         acc;
        logic [3:0] ec;
        pressed = keys;
        for (int i = 1; i <= SCAN_CYC; i++) begin
            if (i == SCAN_CYC / 2 && ack_mode == 1) ack_man = 1'b1;
            if (i == SCAN_CYC && ack_mode == 2) ack_man = 1'b1;
            @(posedge clk);
            #1;
            ecnt++;
            ack_man = 1'b0;
            ec = ~(4'b0001 << ((ecnt / SCAN_DIV) % 4));
            check("col_drive", col_drive, ec);
            if (i == SCAN_CYC / 2 && ack_mode == 1) begin
                m_ready = 0;
                m_ov    = 0;
                check("ack_clears_ready", key_ready, 1'b0);
                check("ack_clears_overrun", overrun, 1'b0);
            end
        end
        res = scan_result(keys);
        if (res == last_res) begin
            run++;
        end else begin
            run      = 1;
            last_res = res;
        end
        acc = 0;
        if (!m_held && res != NONE && run == DEB) begin
            m_held = 1;
            acc    = 1;
        end else if (m_held && res == NONE && run == DEB) begin
            m_held = 0;
        end
        if (acc) begin
            if (m_ready) m_ov = (ack_mode != 2);
            m_ready = 1;
            exp_q.push_back('{code: 4'(res), ov: m_ov});
        end else if (ack_mode == 2 && m_ready) begin
            m_ready = 0;
            m_ov    = 0;
        end
        check("key_held", key_held, m_held);
        if (!auto_en) begin
            check("key_ready", key_ready, m_ready);
            check("overrun", overrun, m_ov);
        end else begin
            m_ready = 0;
            m_ov    = 0;
        end
    endtask

    initial begin : monitor
        logic       pr;
        logic       po;
        logic [3:0] pc;
        exp_t       e;
        pr = 1'b0;
        po = 1'b0;
        pc = 4'd0;
        forever begin
            @(negedge clk);
            if (!reset && ((key_ready && !pr) || (key_ready && key_code != pc) || (overrun && !po))) begin
                if (exp_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_event: got code %0d ready %0b overrun %0b, required no event",
                             key_code, key_ready, overrun);
                end else begin
                    e = exp_q.pop_front();
                    check("event_code", key_code, e.code);
                    check("event_overrun", overrun, e.ov);
                end
            end
            pr = key_ready;
            pc = key_code;
            po = overrun;
        end
    end

    initial begin : consumer
        ack_auto = 1'b0;
        forever begin
            @(negedge clk);
            if (auto_en && key_ready && !reset) begin
                repeat ($urandom_range(0, 4)) @(negedge clk);
                ack_auto = 1'b1;
                @(negedge clk);
                ack_auto = 1'b0;
            end
        end
    end

    initial begin : stimulus
        logic [15:0] pat;
        int          sel;
        reset   = 1'b1;
        pressed = '0;
        ack_man = 1'b0;
        auto_en = 1'b0;
        ecnt    = 0;
        model_reset();
        do_reset();

        repeat (2) scan(16'h0, 0);

        // Key 9 (row 2, col 1) from a fresh reset: accepted at the third scan end.
        do_reset();
        repeat (2) scan(16'h0200, 0);
        check("latency_not_early", key_ready, 1'b0);
        scan(16'h0200, 0);
        check("latency_code", key_code, 4'd9);
        check("latency_ready", key_ready, 1'b1);
        scan(16'h0200, 1);
        repeat (10) scan(16'h0200, 0);
        check("held_no_repeat", key_ready, 1'b0);
        repeat (3) scan(16'h0, 0);

        // Bounce on key 5, then a short release that must not end the hold.
        repeat (2) scan(16'h0020, 0);
        scan(16'h0, 0);
        repeat (2) scan(16'h0020, 0);
        check("bounce_not_early", key_ready, 1'b0);
        scan(16'h0020, 0);
        check("bounce_code", key_code, 4'd5);
        scan(16'h0020, 1);
        repeat (2) scan(16'h0, 0);
        repeat (2) scan(16'h0020, 0);
        check("short_release_held", key_held, 1'b1);
        repeat (3) scan(16'h0, 0);

        // Ghost rejection: keys 0 and 15 together.
        repeat (5) scan(16'h8001, 0);
        check("ghost_no_ready", key_ready, 1'b0);
        scan(16'h0, 0);

        // Two unacknowledged presses: key 3 then key 12.
        repeat (3) scan(16'h0008, 0);
        repeat (3) scan(16'h0, 0);
        repeat (3) scan(16'h1000, 0);
        repeat (3) scan(16'h0, 0);
        check("overrun_code", key_code, 4'd12);
        check("overrun_flag", overrun, 1'b1);
        scan(16'h0, 1);

        // Key 7 accepted, then key 4 accepted on the same edge as an ack.
        repeat (3) scan(16'h0080, 0);
        repeat (3) scan(16'h0, 0);
        repeat (2) scan(16'h0010, 0);
        scan(16'h0010, 2);
        check("ack_accept_code", key_code, 4'd4);
        check("ack_accept_ready", key_ready, 1'b1);
        check("ack_accept_overrun", overrun, 1'b0);

        // Reset in the middle of a scan.
        repeat (5) @(posedge clk);
        #1;
        do_reset();

        // Randomised key activity with an auto-acknowledging consumer.
        auto_en = 1'b1;
        pat     = '0;
        for (int n = 0; n < 80; n++) begin
            if ($urandom_range(0, 99) >= 55) begin
                sel = $urandom_range(0, 99);
                if (sel < 35) pat = 16'h0;
                else if (sel < 85) pat = 16'h1 << $urandom_range(0, 15);
                else pat = (16'h1 << $urandom_range(0, 15)) | (16'h1 << $urandom_range(0, 15));
            end
            scan(pat, 0);
        end
        repeat (4) scan(16'h0, 0);
        auto_en = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        check("scoreboard_drained", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
